// File: rtl/fc_layer_engine_if.sv
// Bus bundle for the fully-connected layer engine: control handshake,
// input-buffer write port, weight/bias memory port, and result read-out.
//
// Ports (engine side, modport slave):
//   in : start, in_wr_en, in_wr_addr, in_wr_data, w_data, b_data, out_rd_addr
//   out: busy, done, w_addr, b_addr, out_rd_data, argmax, argmax_val
interface fc_layer_engine_if #(
    parameter int DATA_W = 16,
    parameter int IN_N   = 64,
    parameter int OUT_N  = 32
);
    localparam int IAW = $clog2(IN_N);
    localparam int WAW = $clog2(IN_N * OUT_N);
    localparam int NAW = $clog2(OUT_N);

    logic              start;
    logic              busy;
    logic              done;
    logic              in_wr_en;
    logic [IAW-1:0]    in_wr_addr;
    logic [DATA_W-1:0] in_wr_data;
    logic [WAW-1:0]    w_addr;
    logic [DATA_W-1:0] w_data;
    logic [NAW-1:0]    b_addr;
    logic [DATA_W-1:0] b_data;
    logic [NAW-1:0]    out_rd_addr;
    logic [DATA_W-1:0] out_rd_data;
    logic [NAW-1:0]    argmax;
    logic [DATA_W-1:0] argmax_val;

    modport slave (
        input  start, in_wr_en, in_wr_addr, in_wr_data,
        input  w_data, b_data, out_rd_addr,
        output busy, done, w_addr, b_addr,
        output out_rd_data, argmax, argmax_val
    );

    modport master (
        output start, in_wr_en, in_wr_addr, in_wr_data,
        output w_data, b_data, out_rd_addr,
        input  busy, done, w_addr, b_addr,
        input  out_rd_data, argmax, argmax_val
    );
endinterface

// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: one MAC per cycle over IN_N inputs for each
// of OUT_N neurons, fixed-point requantise, saturate, optional ReLU, argmax.
//
// Ports: clk, rst_n (async active-low), bus (fc_layer_engine_if.slave).
module fc_layer_engine #(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int IN_N    = 64,
    parameter int OUT_N   = 32,
    parameter int MEM_LAT = 2,
    parameter int RELU_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    fc_layer_engine_if.slave bus
);
    localparam int IAW   = $clog2(IN_N);
    localparam int WAW   = $clog2(IN_N * OUT_N);
    localparam int NAW   = $clog2(OUT_N);
    localparam int ACC_W = 2 * DATA_W + IAW + 1;
    localparam int PRD_W = 2 * DATA_W;
    localparam int CW    = $clog2(IN_N + MEM_LAT + 1);

    localparam logic [CW-1:0]  LAST_CYC  = CW'(IN_N + MEM_LAT - 1);
    localparam logic [CW-1:0]  LAST_K    = CW'(IN_N - 1);
    localparam logic [CW-1:0]  FIRST_MAC = CW'(MEM_LAT);
    localparam logic [NAW-1:0] LAST_N    = NAW'(OUT_N - 1);

    localparam logic signed [ACC_W-1:0] SAT_HI =
        ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STORE,
        S_FIN
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_busy;
    logic   w_done;

    logic [NAW-1:0] r_n;
    logic [CW-1:0]  r_cyc;
    logic [WAW-1:0] r_w_addr;
    logic [NAW-1:0] r_b_addr;

    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_max_val;
    logic [NAW-1:0]           r_max_idx;
    logic [NAW-1:0]           r_argmax;
    logic [DATA_W-1:0]        r_argmax_val;

    logic [DATA_W-1:0] r_in_buf  [2**IAW];
    logic [DATA_W-1:0] r_out_buf [2**NAW];

    logic [IAW-1:0]           w_k;
    logic signed [PRD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_bias_ext;
    logic signed [ACC_W-1:0]  w_shift;
    logic signed [DATA_W-1:0] w_sat;
    logic signed [DATA_W-1:0] w_res;
    logic                     w_take_max;
    logic signed [DATA_W-1:0] w_max_val;
    logic [NAW-1:0]           w_max_idx;

    // Data arriving now belongs to the address issued MEM_LAT cycles ago.
    assign w_k        = IAW'(r_cyc - FIRST_MAC);
    assign w_prod     = $signed(r_in_buf[w_k]) * $signed(bus.w_data);
    assign w_prod_ext = {{(ACC_W - PRD_W){w_prod[PRD_W-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_W - DATA_W - FRAC_W){bus.b_data[DATA_W-1]}},
                         bus.b_data, {FRAC_W{1'b0}}};
    assign w_shift    = r_acc >>> FRAC_W;

    always_comb begin
        w_sat = w_shift[DATA_W-1:0];
        if (w_shift > SAT_HI) begin
            w_sat = SAT_HI[DATA_W-1:0];
        end else if (w_shift < SAT_LO) begin
            w_sat = SAT_LO[DATA_W-1:0];
        end
        w_res = w_sat;
        if (RELU_EN != 0 && w_sat[DATA_W-1]) begin
            w_res = '0;
        end
    end

    // Strictly-greater update keeps the lowest index on ties.
    assign w_take_max = (r_n == '0) || (w_res > r_max_val);
    assign w_max_val  = w_take_max ? w_res : r_max_val;
    assign w_max_idx  = w_take_max ? r_n : r_max_idx;

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_cyc == LAST_CYC) w_next = S_STORE;
            end
            S_STORE: begin
                w_busy = 1'b1;
                w_next = (r_n == LAST_N) ? S_FIN : S_RUN;
            end
            S_FIN: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_n          <= '0;
            r_cyc        <= '0;
            r_w_addr     <= '0;
            r_b_addr     <= '0;
            r_acc        <= '0;
            r_max_val    <= '0;
            r_max_idx    <= '0;
            r_argmax     <= '0;
            r_argmax_val <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_n       <= '0;
                        r_cyc     <= '0;
                        r_w_addr  <= '0;
                        r_b_addr  <= '0;
                        r_max_val <= '0;
                        r_max_idx <= '0;
                    end
                end
                S_RUN: begin
                    r_cyc <= (r_cyc == LAST_CYC) ? '0 : r_cyc + CW'(1);
                    if (r_cyc < LAST_K) begin
                        r_w_addr <= r_w_addr + WAW'(1);
                    end
                    // First returned word also brings the bias in.
                    if (r_cyc == FIRST_MAC) begin
                        r_acc <= w_bias_ext + w_prod_ext;
                    end else if (r_cyc > FIRST_MAC) begin
                        r_acc <= r_acc + w_prod_ext;
                    end
                end
                S_STORE: begin
                    r_max_val <= w_max_val;
                    r_max_idx <= w_max_idx;
                    if (r_n == LAST_N) begin
                        r_argmax     <= w_max_idx;
                        r_argmax_val <= w_max_val;
                    end else begin
                        r_n      <= r_n + NAW'(1);
                        r_w_addr <= r_w_addr + WAW'(1);
                        r_b_addr <= r_b_addr + NAW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (bus.in_wr_en && !w_busy) begin
            r_in_buf[bus.in_wr_addr] <= bus.in_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_STORE) begin
            r_out_buf[r_n] <= w_res;
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.w_addr      = r_w_addr;
    assign bus.b_addr      = r_b_addr;
    assign bus.out_rd_data = r_out_buf[bus.out_rd_addr];
    assign bus.argmax      = r_argmax;
    assign bus.argmax_val  = r_argmax_val;
endmodule

// File: tb/tb_fc_layer_engine.sv
// Bench for fc_layer_engine: two instances (ReLU on / off) share stimulus;
// a cycle-level reference model drives a per-cycle compare process.
module tb_fc_layer_engine;
    localparam int DW   = 16;
    localparam int FW   = 8;
    localparam int IN_N = 4;
    localparam int ON   = 3;
    localparam int LAT  = 2;
    localparam int PER  = IN_N + LAT + 1;
    localparam int BUSY_LEN = ON * PER;
    localparam int RUN_LEN  = ON * PER + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  rd_addr = '0;

    fc_layer_engine_if #(.DATA_W(DW), .IN_N(IN_N), .OUT_N(ON)) ifr ();
    fc_layer_engine_if #(.DATA_W(DW), .IN_N(IN_N), .OUT_N(ON)) ifn ();

    assign ifr.start = start;
    assign ifr.in_wr_en = wr_en;
    assign ifr.in_wr_addr = wr_addr;
    assign ifr.in_wr_data = wr_data;
    assign ifr.out_rd_addr = rd_addr;
    assign ifn.start = start;
    assign ifn.in_wr_en = wr_en;
    assign ifn.in_wr_addr = wr_addr;
    assign ifn.in_wr_data = wr_data;
    assign ifn.out_rd_addr = rd_addr;

    fc_layer_engine #(.DATA_W(DW), .FRAC_W(FW), .IN_N(IN_N), .OUT_N(ON),
                      .MEM_LAT(LAT), .RELU_EN(1)) u_relu (
        .clk(clk), .rst_n(rst_n), .bus(ifr.slave));
    fc_layer_engine #(.DATA_W(DW), .FRAC_W(FW), .IN_N(IN_N), .OUT_N(ON),
                      .MEM_LAT(LAT), .RELU_EN(0)) u_norelu (
        .clk(clk), .rst_n(rst_n), .bus(ifn.slave));

    // Weight / bias memories with LAT-cycle read pipelines.
    logic [15:0] w_mem [16];
    logic [15:0] b_mem [4];
    logic [15:0] wpr [LAT];
    logic [15:0] bpr [LAT];
    logic [15:0] wpn [LAT];
    logic [15:0] bpn [LAT];

    always @(posedge clk) begin
        wpr[0] <= w_mem[ifr.w_addr];
        bpr[0] <= b_mem[ifr.b_addr];
        wpn[0] <= w_mem[ifn.w_addr];
        bpn[0] <= b_mem[ifn.b_addr];
        for (int i = 1; i < LAT; i++) begin
            wpr[i] <= wpr[i-1];
            bpr[i] <= bpr[i-1];
            wpn[i] <= wpn[i-1];
            bpn[i] <= bpn[i-1];
        end
    end
    assign ifr.w_data = wpr[LAT-1];
    assign ifr.b_data = bpr[LAT-1];
    assign ifn.w_data = wpn[LAT-1];
    assign ifn.b_data = bpn[LAT-1];

    int checks = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state.
    logic [15:0] m_in [4];
    logic [15:0] snap [4];
    bit          m_active = 1'b0;
    bit          m_busy;
    int          m_t = 0;
    int          mt_n;
    int          mt_j;
    logic [3:0]  e_w = '0;
    logic [1:0]  e_b = '0;
    logic [1:0]  e_am_r = '0;
    logic [1:0]  e_am_n = '0;
    logic [15:0] e_av_r = '0;
    logic [15:0] e_av_n = '0;
    logic [15:0] e_out_r [3];
    logic [15:0] e_out_n [3];

    function automatic logic [15:0] nout(input int n, input bit relu);
        longint acc;
        longint r;
        logic [15:0] res;
        acc = longint'($signed(b_mem[n])) * 256;
        for (int k = 0; k < IN_N; k++) begin
            acc += longint'($signed(snap[k]))
                 * longint'($signed(w_mem[n*IN_N+k]));
        end
        r = acc >>> FW;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        res = r[15:0];
        return res;
    endfunction

    task automatic finish_run();
        int br;
        int bn;
        for (int i = 0; i < ON; i++) begin
            e_out_r[i] = nout(i, 1'b1);
            e_out_n[i] = nout(i, 1'b0);
        end
        br = 0;
        bn = 0;
        for (int i = 1; i < ON; i++) begin
            if ($signed(e_out_r[i]) > $signed(e_out_r[br])) br = i;
            if ($signed(e_out_n[i]) > $signed(e_out_n[bn])) bn = i;
        end
        e_am_r = 2'(br);
        e_am_n = 2'(bn);
        e_av_r = e_out_r[br];
        e_av_n = e_out_n[bn];
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_t = 0;
            e_w = '0;
            e_b = '0;
            e_am_r = '0;
            e_am_n = '0;
            e_av_r = '0;
            e_av_n = '0;
        end else begin
            m_busy = m_active && (m_t < BUSY_LEN);
            if (wr_en && !m_busy) m_in[wr_addr] = wr_data;
            if (m_active) begin
                m_t++;
                if (m_t < BUSY_LEN) begin
                    mt_n = m_t / PER;
                    mt_j = m_t % PER;
                    if (mt_j > IN_N - 1) mt_j = IN_N - 1;
                    e_b = 2'(mt_n);
                    e_w = 4'(mt_n * IN_N + mt_j);
                end else if (m_t == BUSY_LEN) begin
                    finish_run();
                end else begin
                    m_active = 1'b0;
                end
            end else if (start) begin
                m_active = 1'b1;
                m_t = 0;
                snap = m_in;
                e_w = '0;
                e_b = '0;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic eb;
        logic ed;
        eb = m_active && (m_t < BUSY_LEN);
        ed = m_active && (m_t == BUSY_LEN);
        check("busy_r", ifr.busy, eb);
        check("busy_n", ifn.busy, eb);
        check("done_r", ifr.done, ed);
        check("done_n", ifn.done, ed);
        check("waddr_r", ifr.w_addr, e_w);
        check("waddr_n", ifn.w_addr, e_w);
        check("baddr_r", ifr.b_addr, e_b);
        check("baddr_n", ifn.b_addr, e_b);
        check("argmax_r", ifr.argmax, e_am_r);
        check("argmax_n", ifn.argmax, e_am_n);
        check("amval_r", ifr.argmax_val, e_av_r);
        check("amval_n", ifn.argmax_val, e_av_n);
    end

    int trace [$];

    task automatic wr_in(input logic [1:0] a, input logic [15:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic load_in(input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] a2, input logic [15:0] a3);
        wr_in(2'd0, a0);
        wr_in(2'd1, a1);
        wr_in(2'd2, a2);
        wr_in(2'd3, a3);
    endtask

    task automatic set_w_all(input logic [15:0] v);
        for (int i = 0; i < 16; i++) w_mem[i] = v;
    endtask

    task automatic set_b(input logic [15:0] b0, input logic [15:0] b1,
                         input logic [15:0] b2);
        b_mem[0] = b0;
        b_mem[1] = b1;
        b_mem[2] = b2;
        b_mem[3] = 16'h0;
    endtask

    // lat counts rising edges from the accept edge through the edge
    // that raises done.
    task automatic run_layer(input int poke_at, input bit wr_with_start,
                             input logic [15:0] wdat, output int lat);
        start = 1'b1;
        if (wr_with_start) begin
            wr_en = 1'b1;
            wr_addr = 2'd0;
            wr_data = wdat;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        lat = 1;
        trace.delete();
        trace.push_back(int'(ifr.w_addr));
        while (ifr.done !== 1'b1 && lat < 100) begin
            if (lat == poke_at) begin
                start = 1'b1;
                wr_en = 1'b1;
                wr_addr = 2'd0;
                wr_data = wdat;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            wr_en = 1'b0;
            lat++;
            trace.push_back(int'(ifr.w_addr));
        end
        if (lat >= 100) check("done_timeout", 32'(lat), 32'(RUN_LEN));
        @(posedge clk);
        #1;
    endtask

    task automatic read_out();
        for (int i = 0; i < ON; i++) begin
            rd_addr = 2'(i);
            #1;
            check("out_r", ifr.out_rd_data, e_out_r[i]);
            check("out_n", ifn.out_rd_data, e_out_n[i]);
        end
    endtask

    task automatic rd_r(input int i, output logic [15:0] vr,
                        output logic [15:0] vn);
        rd_addr = 2'(i);
        #1;
        vr = ifr.out_rd_data;
        vn = ifn.out_rd_data;
    endtask

    initial begin
        int lat;
        logic [15:0] vr;
        logic [15:0] vn;

        for (int i = 0; i < 16; i++) w_mem[i] = '0;
        for (int i = 0; i < 4; i++) begin
            b_mem[i] = '0;
            m_in[i] = '0;
            snap[i] = '0;
        end

        @(posedge clk);
        #1;
        check("rst_busy", ifr.busy, 1'b0);
        check("rst_done", ifr.done, 1'b0);
        check("rst_waddr", ifr.w_addr, 4'd0);
        check("rst_baddr", ifn.b_addr, 2'd0);
        check("rst_argmax", ifr.argmax, 2'd0);
        check("rst_amval", ifn.argmax_val, 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic run.
        load_in(16'h0100, 16'h0200, 16'h0000, 16'hFF00);
        set_w_all(16'h0080);
        set_b(16'h0000, 16'h0100, 16'hFC00);
        run_layer(0, 1'b0, 16'h0, lat);
        check("lat_basic", 32'(lat), 32'd22);
        check("trace0", 32'(trace[0]), 32'd0);
        check("trace3", 32'(trace[3]), 32'd3);
        check("trace6", 32'(trace[6]), 32'd3);
        check("trace7", 32'(trace[7]), 32'd4);
        check("trace14", 32'(trace[14]), 32'd8);
        check("trace20", 32'(trace[20]), 32'd11);
        read_out();
        rd_r(0, vr, vn);
        check("basic_o0", vr, 16'h0100);
        rd_r(1, vr, vn);
        check("basic_o1", vr, 16'h0200);
        rd_r(2, vr, vn);
        check("basic_o2_relu", vr, 16'h0000);
        check("basic_o2_raw", vn, 16'hFD00);
        check("basic_argmax", ifr.argmax, 2'd1);
        check("basic_amval", ifr.argmax_val, 16'h0200);

        // Positive saturation.
        load_in(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
        set_w_all(16'h7F00);
        set_b(16'h0, 16'h0, 16'h0);
        run_layer(0, 1'b0, 16'h0, lat);
        read_out();
        rd_r(1, vr, vn);
        check("sat_pos", vr, 16'h7FFF);
        check("sat_argmax", ifr.argmax, 2'd0);

        // Negative saturation.
        set_w_all(16'h8100);
        run_layer(0, 1'b0, 16'h0, lat);
        read_out();
        rd_r(2, vr, vn);
        check("sat_neg_raw", vn, 16'h8000);
        check("sat_neg_relu", vr, 16'h0000);

        // Tie on outputs {3.0, 3.0, 1.0}.
        load_in(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        set_w_all(16'h0000);
        set_b(16'h0300, 16'h0300, 16'h0100);
        run_layer(0, 1'b0, 16'h0, lat);
        read_out();
        check("tie_argmax", ifr.argmax, 2'd0);
        check("tie_amval", ifr.argmax_val, 16'h0300);

        // Floor rounding, with an input write accepted alongside start.
        load_in(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < 16; i++) w_mem[i] = 16'(16'h0111 * i);
        w_mem[0] = 16'h0080;
        w_mem[4] = 16'hFF80;
        w_mem[8] = 16'h0300;
        set_b(16'h0, 16'h0, 16'h0);
        run_layer(0, 1'b1, 16'hFFFF, lat);
        read_out();
        rd_r(0, vr, vn);
        check("floor_raw0", vn, 16'hFFFF);
        check("floor_argmax_n", ifn.argmax, 2'd1);

        // Distinct weight per address.
        load_in(16'h0100, 16'hFF80, 16'h0040, 16'h0200);
        for (int i = 0; i < 16; i++) w_mem[i] = 16'(32'h0020 * i - 32'h0090);
        set_b(16'h0010, 16'hFFF0, 16'h0000);
        run_layer(0, 1'b0, 16'h0, lat);
        read_out();

        // Start and write pulsed mid-run must be dropped.
        run_layer(5, 1'b0, 16'h1234, lat);
        check("lat_poke", 32'(lat), 32'd22);
        read_out();
        run_layer(0, 1'b0, 16'h0, lat);
        read_out();

        // Reset partway through a run.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", ifr.busy, 1'b0);
        check("abort_done", ifn.done, 1'b0);
        check("abort_argmax", ifr.argmax, 2'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_layer(0, 1'b0, 16'h0, lat);
        check("lat_after_rst", 32'(lat), 32'd22);
        read_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/fc_layer_engine.md
FC_LAYER_ENGINE -- requirements
Module: fc_layer_engine

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- DATA_W, 16, signed fixed-point word width.
- FRAC_W, 8, fractional bits.
- IN_N, 64, input vector length.
- OUT_N, 32, neuron count.
- MEM_LAT, 2, weight/bias memory read latency in cycles, 1..4.
- RELU_EN, 1, 1 applies ReLU to stored outputs.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, sole clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin layer evaluation.
- busy, out, 1, evaluation in progress.
- done, out, 1, one-cycle completion pulse.
- in_wr_en, in, 1, input buffer write strobe.
- in_wr_addr, in, clog2(IN_N), input buffer index.
- in_wr_data, in, DATA_W, input activation.
- w_addr, out, clog2(IN_N*OUT_N), weight address.
- w_data, in, DATA_W, weight read data.
- b_addr, out, clog2(OUT_N), bias address.
- b_data, in, DATA_W, bias read data.
- out_rd_addr, in, clog2(OUT_N), output buffer index.
- out_rd_data, out, DATA_W, combinational read of the output buffer.
- argmax, out, clog2(OUT_N), index of the largest output.
- argmax_val, out, DATA_W, value of the largest output.
REQ-003 Reset SHALL be asynchronous and active-low on rst_n, and clk SHALL be the only clock.

Function
REQ-004 The FSM SHALL have the states IDLE, RUN, STORE and FIN; start SHALL be sampled only in IDLE, and start while busy SHALL be ignored.
REQ-005 On start in IDLE, the block SHALL go to RUN, set busy=1, set the neuron counter n=0 and the address counter k=0, and clear the running argmax.
REQ-006 For each neuron, in RUN cycles 0..IN_N-1, w_addr SHALL equal n*IN_N+k with k incrementing by 1 per cycle, and b_addr SHALL equal n.
REQ-007 Read data SHALL be taken exactly MEM_LAT cycles after its address, with no back-pressure and one MAC per cycle.
REQ-008 The accumulator SHALL be signed, 2*DATA_W+clog2(IN_N)+1 bits wide, and SHALL be initialised to b_data<<FRAC_W.
REQ-009 Each MAC SHALL add in_buf[k]*w_data as a full-precision signed product.
REQ-010 After the last MAC (RUN cycle IN_N+MEM_LAT-1), the FSM SHALL enter STORE for one cycle.
REQ-011 In STORE, the result SHALL be acc>>>FRAC_W, arithmetic, truncated toward negative infinity.
REQ-012 The STORE result SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1], and ReLU (negative to 0) SHALL be applied after saturation if RELU_EN=1.
REQ-013 The STORE result SHALL be written to out_buf[n] and compared to the running maximum, signed; the update SHALL happen only on strictly greater, so the lowest index wins ties; neuron 0 SHALL always load the maximum.
REQ-014 Per-neuron time SHALL be IN_N+MEM_LAT+1 cycles; after STORE of neuron n<OUT_N-1, n SHALL increment and RUN restart with k=0.
REQ-015 After STORE of neuron OUT_N-1, the FSM SHALL enter FIN: done=1 for exactly one cycle, busy=0, argmax and argmax_val updated, then IDLE.
REQ-016 Latency from the start-accept edge to the done cycle SHALL be OUT_N*(IN_N+MEM_LAT+1)+1 cycles.
REQ-017 argmax and argmax_val SHALL change only in FIN and SHALL hold between runs; out_buf SHALL hold between runs.
REQ-018 in_wr_en SHALL write in_buf only when busy=0; writes while busy SHALL be dropped.
REQ-019 start in the same cycle as in_wr_en in IDLE SHALL accept both, and the evaluation SHALL use the old in_buf[in_wr_addr] only for k where the read precedes the write; no bypass SHALL be provided.
REQ-020 w_addr and b_addr SHALL hold their last value outside RUN.

Reset
REQ-021 While rst_n=0, outputs SHALL be: busy=0, done=0, argmax=0, argmax_val=0, w_addr=0, b_addr=0, with the FSM in IDLE and counters at 0.
REQ-022 in_buf and out_buf SHALL NOT be reset.
REQ-023 Reset during RUN or STORE SHALL abort the evaluation; done SHALL NOT pulse, and the next start SHALL begin a full fresh evaluation.

Verification (IN_N=4, OUT_N=3, MEM_LAT=2, DATA_W=16, FRAC_W=8)
REQ-024 Basic run: in_buf={1.0,2.0,0,-1.0}, all weights 0.5, biases {0,1.0,-4.0} -> out_buf={1.0,2.0,0} (neuron 2 ReLU-clamped from -3.0), argmax=1, argmax_val=0x0200, done at cycle 22.
REQ-025 Saturation: in_buf all 127.0, weights all 127.0 -> out_buf entries 0x7FFF; with RELU_EN=0 and weights all -127.0 -> 0x8000.
REQ-026 Tie: outputs {3.0,3.0,1.0} -> argmax=0.
REQ-027 Protocol: pulse start and in_wr_en at cycle 5 of a run -> no restart, in_buf unchanged, single done, latency unchanged.
REQ-028 Reset: assert rst_n=0 at cycle 10 of a run -> busy=0 and done=0 immediately; a new start yields correct results at cycle 22.
REQ-029 Address trace: the w_addr sequence SHALL be 0..3, 4..7, 8..11, each group of 4 consecutive cycles separated by 3 idle cycles (IN_N+MEM_LAT+1 = 7-cycle neuron period, w_addr held); b_addr = 0, 1, 2 per neuron.
